push_capture_fifo: RTL and testbench

PUSH_CAPTURE_FIFO -- requirements
Module: push_capture_fifo

---
 rtl/push_capture_fifo.sv | 91 +++++++++
 tb/tb_push_capture_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/push_capture_fifo.sv
// Single-clock FIFO that captures pre-synchronized push strobes and serves registered pops.
// Pointers carry one extra wrap bit, so full and empty both fall out of their difference.
module push_capture_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              push_pulse,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic [ADDR_W:0]   w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_pop_acc;
    logic              w_push_acc;
    logic              w_ovf_event;
    logic              w_unf_event;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == DEPTH_CNT);
    assign w_empty = (w_count == '0);

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign w_pop_acc   = pop & ~w_empty;
    assign w_push_acc  = push_pulse & (~w_full | w_pop_acc);
    assign w_ovf_event = push_pulse & ~w_push_acc;
    assign w_unf_event = pop & w_empty;

    // NOTE: the storage array has no reset; entries are only read after being written.
    always_ff @(posedge wclk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values, which
    // lets a full-FIFO pop read the old word in the slot the push overwrites.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_dout_valid <= w_pop_acc;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            end
            // A fresh error in the clearing cycle keeps the flag set.
            r_overflow  <= w_ovf_event | (r_overflow & ~clr_err);
            r_underflow <= w_unf_event | (r_underflow & ~clr_err);
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = w_count;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_push_capture_fifo.sv
// Bench for push_capture_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_push_capture_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          wclk       = 1'b0;
    logic          rst        = 1'b1;
    logic          push_pulse = 1'b0;
    logic [DW-1:0] din        = '0;
    logic          pop        = 1'b0;
    logic          clr_err    = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fail   = 0;

    push_capture_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .wclk       (wclk),
        .rst        (rst),
        .push_pulse (push_pulse),
        .din        (din),
        .pop        (pop),
        .clr_err    (clr_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words plus the observable registers.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_ovf;
    logic          m_unf;
    bit            m_pop_ok;
    bit            m_push_ok;
    bit            m_was_full;
    bit            m_was_empty;

    always @(posedge wclk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            m_was_full  = (mq.size() == DEPTH);
            m_was_empty = (mq.size() == 0);
            m_pop_ok    = pop && !m_was_empty;
            m_push_ok   = push_pulse && (!m_was_full || m_pop_ok);
            m_valid     = m_pop_ok;
            if (m_pop_ok) m_dout = mq.pop_front();
            if (m_push_ok) mq.push_back(din);
            m_ovf = (push_pulse && !m_push_ok) || (m_ovf && !clr_err);
            m_unf = (pop && m_was_empty) || (m_unf && !clr_err);
        end
    end

    always @(negedge wclk) begin
        check("count",      32'(count),      32'(mq.size()));
        check("full",       32'(full),       32'(mq.size() == DEPTH));
        check("empty",      32'(empty),      32'(mq.size() == 0));
        check("dout",       32'(dout),       32'(m_dout));
        check("dout_valid", 32'(dout_valid), 32'(m_valid));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("underflow",  32'(underflow),  32'(m_unf));
    end

    task automatic step(input logic p, input logic [DW-1:0] d, input logic po, input logic c);
        push_pulse = p;
        din        = d;
        pop        = po;
        clr_err    = c;
        @(posedge wclk);
        #1;
        push_pulse = 1'b0;
        pop        = 1'b0;
        clr_err    = 1'b0;
    endtask

    initial begin
        int w;
        int r;
        @(posedge wclk);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full), 0);
        check("rst_dout",  32'(dout), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_flags", {30'd0, overflow, underflow}, 0);
        @(posedge wclk);
        #2 rst = 1'b0;
        @(posedge wclk);
        #1;

        // Three pushes then three pops, one-cycle read latency.
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b0, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 8'hB2, 1'b0, 1'b0);
        step(1'b0, 8'hB2, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        check("basic_count3", 32'(count), 3);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("basic_pop1", {23'd0, dout_valid, dout}, 32'h1A1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("basic_valid_drop", 32'(dout_valid), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("basic_pop2", {23'd0, dout_valid, dout}, 32'h1B2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("basic_pop3", {23'd0, dout_valid, dout}, 32'h1C3);
        check("basic_empty", 32'(empty), 1);

        // Fill, overflow, drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_full",  32'(full), 1);
        check("ovf_count", 32'(count), 16);
        check("ovf_flag",  32'(overflow), 1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_word", {23'd0, dout_valid, dout}, 32'h100 | 32'(i));
        end
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("drain_hold", {23'd0, dout_valid, dout}, 32'h00F);
        check("clr_ovf", 32'(overflow), 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous push and pop on a full FIFO.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("fullpp_count", 32'(count), 16);
        check("fullpp_ovf",   32'(overflow), 0);
        check("fullpp_dout",  {23'd0, dout_valid, dout}, 32'h120);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            if (i == DEPTH - 1) check("fullpp_last", 32'(dout), 32'h55);
        end

        // Underflow and clear priority.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_set",   32'(underflow), 1);
        check("unf_valid", 32'(dout_valid), 0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("unf_sticky", 32'(underflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clear", 32'(underflow), 0);

        // Streaming at occupancy 3 across pointer wraps.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h83 + i), 1'b1, 1'b0);
            check("stream_word",  32'(dout), 32'(8'h80 + i));
            check("stream_count", 32'(count), 3);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_tail", 32'(dout), 32'hAA);

        // Mid-operation reset.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mrst_count", 32'(count), 0);
        check("mrst_empty", 32'(empty), 1);
        check("mrst_dout",  32'(dout), 0);
        @(posedge wclk);
        #2 rst = 1'b0;
        @(posedge wclk);
        #1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("mrst_new", {23'd0, dout_valid, dout}, 32'h13C);

        // Randomized soak: alternate push-heavy and pop-heavy phases to visit full and empty.
        for (int ph = 0; ph < 8; ph++) begin
            w = (ph % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 250; i++) begin
                r = $urandom_range(0, 99);
                step(r < w, 8'($urandom), $urandom_range(0, 99) < 50, $urandom_range(0, 19) == 0);
            end
        end

        repeat (2) @(posedge wclk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
